// File: rtl/count_updn_mod.sv
// count_updn_mod
//   Parametrised up/down modulo counter with prescaler, synchronous clear,
//   parallel load, wrap/saturate mode and a registered terminal-count pulse.
//   Used as a general event/timebase counter for die-level sequencing.
//
// Parameters
//   WIDTH  counter width (>= 2)
//   DIV    prescale ratio: one count step per DIV enabled cycles (>= 1)
//   OVF_W  width of the saturating wrap-event counter
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load of load_val
//   load_val  value captured on load (may exceed max_val)
//   en        count enable, feeds the prescaler
//   up        1 = count up, 0 = count down
//   sat       1 = saturate at limits, 0 = wrap modulo (max_val+1)
//   max_val   top of the count range [0..max_val], sampled every cycle
//   cnt       current count (registered)
//   tc        terminal-count pulse (registered, one cycle per event)
//   wraps     wrap events since reset/clr, saturating at all-ones
module count_updn_mod #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1,
  parameter int unsigned OVF_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic [OVF_W-1:0] wraps
);

  logic             step;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             wrap_evt;

  // Prescaler: with DIV=1 every enabled cycle is a step and no register exists.
  generate
    if (DIV == 1) begin : g_nopre
      assign step = en;
    end else begin : g_pre
      localparam int unsigned PW = $clog2(DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
      logic [PW-1:0] pre;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre <= '0;
        end else if (clr || load) begin
          pre <= '0;
        end else if (en) begin
          pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
      end

      assign step = en && (pre == PRE_LAST);
    end
  endgenerate

  // Next count and event flags for a step; only applied when step is taken.
  always_comb begin
    cnt_nxt  = cnt;
    tc_nxt   = 1'b0;
    wrap_evt = 1'b0;
    if (up) begin
      if (cnt < max_val) begin
        cnt_nxt = cnt + WIDTH'(1);
        tc_nxt  = sat && (cnt_nxt == max_val);
      end else if (!sat) begin
        cnt_nxt  = '0;
        tc_nxt   = 1'b1;
        wrap_evt = 1'b1;
      end else begin
        // Saturated: a count loaded above max_val clamps down and flags it.
        cnt_nxt = max_val;
        tc_nxt  = (cnt > max_val);
      end
    end else begin
      if (cnt == '0) begin
        if (!sat) begin
          cnt_nxt  = max_val;
          tc_nxt   = 1'b1;
          wrap_evt = 1'b1;
        end
      end else if (cnt <= max_val) begin
        cnt_nxt = cnt - WIDTH'(1);
        tc_nxt  = sat && (cnt_nxt == '0);
      end else begin
        cnt_nxt = max_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      tc    <= 1'b0;
      wraps <= '0;
    end else if (clr) begin
      cnt   <= '0;
      tc    <= 1'b0;
      wraps <= '0;
    end else if (load) begin
      cnt <= load_val;
      tc  <= 1'b0;
    end else if (step) begin
      cnt <= cnt_nxt;
      tc  <= tc_nxt;
      if (wrap_evt && (wraps != '1)) begin
        wraps <= wraps + OVF_W'(1);
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
